// File: rtl/bcd_scan_driver_if.sv
// bcd_scan_driver_if
//   Bundles the request and display signals of bcd_scan_driver.
//   load  : start-conversion strobe (master -> driver)
//   val   : 8-bit binary value to convert (master -> driver)
//   busy  : conversion in progress (driver -> master)
//   done  : one-cycle pulse when a new result is committed (driver -> master)
//   d     : digit code of the scanned position (driver -> decoder)
//   an    : active-low one-hot digit enable (driver -> display)
//   state_dbg : 1 while the conversion FSM is in CONV (observation only)
//
//   Handshake: load is a level sampled on every rising clk edge; it is
//   accepted only when busy=0 at that edge. There is no ready/queue, so a
//   load seen while busy (including the edge on which busy falls) is dropped.
interface bcd_scan_driver_if;
    logic       load;
    logic [7:0] val;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic [3:0] an;
    logic       state_dbg;

    modport master (
        output load, val,
        input  busy, done, d, an, state_dbg
    );

    modport slave (
        input  load, val,
        output busy, done, d, an, state_dbg
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
//   Converts an 8-bit binary value to BCD with a sequential shift-add-3
//   (double-dabble), one shift per clock, stores the result in a 4-digit
//   display register and time-multiplexes it onto a 7-segment decoder.
//
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     bus    : bcd_scan_driver_if.slave (load, val, busy, done, d, an,
//              state_dbg)
//
//   Parameters:
//     SCAN_DIV : cycles each digit stays enabled (1..65535)
//
//   Build option:
//     BCD_SCAN_SIGNED_EN : when defined, val is two's complement; negative
//                          values convert their magnitude and position 3
//                          shows 4'hA (rendered as '-' by the decoder).
//                          Undefined: val is unsigned, position 3 is 0.
//
//   Digit positions: 0 = units, 1 = tens, 2 = hundreds, 3 = sign/spare.
module bcd_scan_driver #(
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    bcd_scan_driver_if.slave  bus
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state;
    logic [7:0]      bin;
    logic [11:0]     bcd;
    logic [2:0]      bitcnt;
    logic [3:0]      sign_nib;
    logic [3:0][3:0] disp;
    logic [15:0]     scan_cnt;
    logic [1:0]      idx;
    logic            busy_r;
    logic            done_r;
    logic [3:0]      d_r;
    logic [3:0]      an_r;

    // Values captured on an accepted load.
    logic [7:0]      mag;
    logic [3:0]      sign_in;

    // One double-dabble step, and the next-cycle views of the display and
    // scan index. d/an are registered from these so they always match the
    // display register and index of the same cycle.
    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_nxt;
    logic [7:0]      bin_nxt;
    logic            last_step;
    logic [3:0][3:0] disp_nxt;
    logic [1:0]      idx_nxt;
    logic            scan_wrap;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
`ifdef BCD_SCAN_SIGNED_EN
        mag     = bus.val[7] ? (~bus.val + 8'd1) : bus.val;
        sign_in = bus.val[7] ? 4'hA : 4'h0;
`else
        mag     = bus.val;
        sign_in = 4'h0;
`endif
    end

    always_comb begin
        bcd_adj            = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
        last_step          = (state == CONV) && (bitcnt == 3'd7);

        disp_nxt = disp;
        if (last_step) begin
            disp_nxt[0] = bcd_nxt[3:0];
            disp_nxt[1] = bcd_nxt[7:4];
            disp_nxt[2] = bcd_nxt[11:8];
            disp_nxt[3] = sign_nib;
        end

        scan_wrap = (scan_cnt == SCAN_LAST);
        idx_nxt   = scan_wrap ? idx + 2'd1 : idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= 8'h00;
            bcd      <= 12'h000;
            bitcnt   <= 3'd0;
            sign_nib <= 4'h0;
            disp     <= '0;
            scan_cnt <= 16'd0;
            idx      <= 2'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            d_r      <= 4'h0;
            an_r     <= 4'b1110;
        end else begin
            done_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin      <= mag;
                        sign_nib <= sign_in;
                        bcd      <= 12'h000;
                        bitcnt   <= 3'd0;
                        busy_r   <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= bcd_nxt;
                    bin    <= bin_nxt;
                    bitcnt <= bitcnt + 3'd1;
                    if (last_step) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Display is only rewritten on the final step, so it holds the
            // previous result for the whole conversion.
            disp <= disp_nxt;

            // Free-running scan, independent of the FSM.
            scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
            idx      <= idx_nxt;
            an_r     <= ~(4'b0001 << idx_nxt);
            d_r      <= disp_nxt[idx_nxt];
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.d         = d_r;
    assign bus.an        = an_r;
    assign bus.state_dbg = (state == CONV);

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Upstream stage of the 7-segment decoder (4-bit digit code in, 8-bit segment pattern out).
- Converts an 8-bit binary value to BCD digits using a sequential shift-add-3 (double-dabble) algorithm, one shift per clock.
- Holds the result in a 4-digit display register and time-multiplexes it: it drives one digit code to the decoder's input at a time, plus the matching active-low digit enable.

Parameters:
- SCAN_DIV, 16, clock cycles each digit stays active; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  start-conversion strobe; sampled only when idle
- val  input  8  binary value to display; captured on an accepted load
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse on the edge that commits a new result
- d  output  4  digit code for the currently scanned position; feeds the decoder
- an  output  4  active-low one-hot digit enable; an[i]=0 means position i is lit

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: busy=0, done=0, display digits {3,2,1,0} = 0, scan index=0, scan counter=0, an=4'b1110, d=4'h0.
- Digit positions: position 0 = units, 1 = tens, 2 = hundreds, 3 = sign/spare.
- FSM has two states, IDLE and CONV.
- IDLE:
  - A load=1 sampled at a rising edge captures val (or its magnitude, see Optional Feature) into the shift register.
  - The same edge clears the BCD accumulator (12 bits), sets the bit counter to 0, enters CONV and sets busy=1.
- CONV, one double-dabble step per cycle:
  - Add 3 to each BCD nibble that is >= 5.
  - Then shift {bcd, bin} left by one.
  - Increment the bit counter.
- After the 8th step:
  - The display register is written atomically from the final BCD value: position 0 = units, 1 = tens, 2 = hundreds, 3 = sign nibble.
  - busy goes to 0, done=1 for exactly one cycle, and the FSM returns to IDLE.
- Latency: busy is high for exactly 8 cycles. done and the new digits appear on the 8th edge after the load edge.
- load while busy is ignored; no queueing. load on the same edge that busy falls is also ignored. The earliest accepted reload is the cycle after done.
- The display register holds the previous result throughout a conversion, so there is no visible glitch.
- Scan logic runs continuously and independently of the FSM:
  - The counter counts 0..SCAN_DIV-1.
  - On wrap, the index advances 0→1→2→3→0.
  - an = ~(4'b0001 << index); d = digit[index]. Both are registered and change on the same edge.
- SCAN_DIV=1: the index advances every cycle.
- Reset mid-conversion: the conversion is aborted, busy=0, no done pulse, and the display is cleared to 0.
- Max unsigned value 255 → digits 0,2,5,5. BCD nibbles never exceed 9.

Optional Feature:
- Macro: BCD_SCAN_SIGNED_EN.
- Defined:
  - val is two's complement. If val[7]=1, the magnitude (-val, 8-bit unsigned, so 0x80 → 128) is converted and position 3 is written as 4'hA. The decoder maps out-of-range codes to its dash pattern, showing '-'.
  - If val[7]=0, position 3 is 4'h0.
- Undefined: val is unsigned and position 3 is always 4'h0.
- Timing and latency are identical in both builds.

Test Plan:
- Reset, SCAN_DIV=4, no load → an cycles 1110,1101,1011,0111 every 4 cycles with d=0 throughout; the index returns to position 0 after 16 cycles.
- load with val=8'd255 → busy high exactly 8 cycles, one done pulse, then d shows 5,5,2,0 at positions 0..3; display unchanged before done.
- load val=8'd37, then pulse load with val=8'd99 during busy → result 7,3,0,0; the second load is ignored, with only one done pulse.
- Signed build, val=8'h80 → positions 0..3 = 8,2,1,A. val=8'hFF → 1,0,0,A. Unsigned build, val=8'h80 → 8,2,1,0.
- Display showing 255, then load val=8'd12 and assert reset on the 4th conversion cycle → busy=0 and done=0 the next cycle, all digits 0, an=1110.
- load held high continuously with val=8'd9 → a new conversion is accepted every 9 cycles (8 busy + 1 idle), with a done pulse each time and digits stable at 9,0,0,0.
